tt_sweep_ctrl: RTL and testbench
================================

// Module: tt_sweep_ctrl
// PURPOSE
//   Sequencer for the 3-input combinational function unit (f = xy + yz + x'z).
//   On start, drives the unit's x/y/z inputs through all 8 input vectors in order 000..111.
//   It holds each vector for a programmable dwell time, then samples f into a truth-table register.
//   At the end it compares the captured table against an expected mask and reports pass/fail.
//   Sits beside the function unit as its built-in self-test / characterisation controller.
// PARAMETERS
//   DWELL     4      cycles each vector is held before sampling; legal 1..255
//   EXPECTED  8'hCA  golden truth table, bit i = f for {x,y,z}=i (f=1 at i=1,3,6,7)
// PORTS
//   clk           in   1  rising-edge clock
//   rst           in   1  asynchronous, active-high reset
//   start         in   1  1-cycle request to begin a sweep; accepted in IDLE or DONE only
//   hold          in   1  pause: freezes dwell counter, vector index and state while high
//   f_in          in   1  f output returned from the function unit
//   x, y, z       out  1  vector driven to the function unit; {x,y,z} = current index
//   busy          out  1  high from the cycle after start is accepted until DONE is entered
//   done          out  1  1-cycle pulse in the DONE state
//   pass          out  1  captured table == EXPECTED; valid from done until next accepted start
//   table_out     out  8  captured truth table, bit i = f_in sampled for vector i
//   mismatch_cnt  out  4  number of vectors differing from EXPECTED (0..8)
//   fail_valid    out  1  at least one mismatch seen this sweep
//   fail_idx      out  3  index of first mismatching vector; valid when fail_valid
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; idx=0; dwell counter=0.
//     All outputs 0: x,y,z,busy,done,pass,table_out,mismatch_cnt,fail_valid,fail_idx.
//   - FSM states: IDLE, APPLY, SAMPLE, DONE.
//   - IDLE: x,y,z hold last value. start=1 -> APPLY with idx=0 and cnt=DWELL-1.
//     Same edge clears table_out, mismatch_cnt, fail_valid, fail_idx and pass.
//   - APPLY: drive {x,y,z}=idx. If cnt!=0, decrement cnt. If cnt==0, go to SAMPLE.
//     Result: each vector is held DWELL cycles in APPLY before its sample.
//   - SAMPLE: on the edge leaving SAMPLE:
//       table_out[idx] <= f_in;
//       if f_in != EXPECTED[idx]: mismatch_cnt++; if !fail_valid, set fail_idx=idx and fail_valid=1.
//     Then if idx==7 -> DONE; else idx++, cnt=DWELL-1, -> APPLY.
//   - DONE: done=1 for exactly this cycle; busy=0.
//     pass = (mismatch_cnt==0), registered on the DONE entry edge using the final count.
//     Next: start=1 -> APPLY (restart, same clears as IDLE); else -> IDLE.
//   - hold=1 in APPLY/SAMPLE: no state, idx, cnt or capture update; outputs stable.
//     hold is ignored in IDLE and DONE.
//   - start while busy (APPLY/SAMPLE) is ignored; no restart and no effect on results.
//   - Latency without hold: start edge to done = 8*(DWELL+1) cycles (DWELL=4 -> 40 cycles).
//     Each held hold cycle adds 1.
//   - f_in is sampled only in SAMPLE, at least DWELL cycles after the vector changed.
//     This allows for multi-cycle combinational settling in the unit.
//   - mismatch_cnt saturates naturally at 8 (4-bit field, max 8 vectors); no wrap.
//   - idx is 3 bits; the 7 -> DONE exit is decoded explicitly, never by wrap-around.
//   - Reset mid-sweep aborts immediately. No partial results are retained and done is not pulsed.
// TESTING
//   1 Reset: rst=1 mid-run -> every output 0 asynchronously; after release, state IDLE, busy=0.
//   2 Good unit, DWELL=4: start pulse -> x,y,z step 000..111, 5 cycles per vector.
//     done at cycle 40 with table_out=8'hCA, pass=1, mismatch_cnt=0, fail_valid=0.
//   3 Faulty unit, f_in stuck 0: table_out=8'h00, pass=0, mismatch_cnt=4, fail_valid=1, fail_idx=1.
//   4 Hold: raise hold for 7 cycles during vector 3 -> vector 3 held 12 cycles.
//     done at cycle 47; results identical to test 2.
//   5 Start while busy: pulse start at cycle 10 -> ignored, done still at cycle 40.
//     Then start in the done cycle -> immediate restart: busy=1 next cycle, table_out cleared.
//   6 DWELL=1 bench: done at cycle 16.
//     Inverted-f unit -> table_out=8'h35, mismatch_cnt=8, fail_idx=0.

Source files
------------

// File: rtl/tt_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl_if
//   Bundles the request/observation signals between the truth-table sweep
//   controller and whatever drives and watches it (system logic or a bench).
//
//   Signals
//     start         1  request to begin a sweep
//     hold          1  pause the sweep while high
//     f_in          1  f returned from the function unit
//     x, y, z       1  vector presented to the function unit
//     busy          1  sweep in progress
//     done          1  one-cycle end-of-sweep pulse
//     pass          1  captured table matched the golden table
//     table_out     8  captured truth table
//     mismatch_cnt  4  number of vectors that differed from golden
//     fail_valid    1  at least one mismatch this sweep
//     fail_idx      3  first mismatching vector index
//
//   Modports
//     master  requester side: drives start/hold/f_in, observes the rest
//     slave   the sweep controller itself
// ---------------------------------------------------------------------------
interface tt_sweep_ctrl_if;
   logic       start;
   logic       hold;
   logic       f_in;
   logic       x;
   logic       y;
   logic       z;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] table_out;
   logic [3:0] mismatch_cnt;
   logic       fail_valid;
   logic [2:0] fail_idx;

   modport master (
      output start, hold, f_in,
      input  x, y, z, busy, done, pass, table_out, mismatch_cnt,
             fail_valid, fail_idx
   );

   modport slave (
      input  start, hold, f_in,
      output x, y, z, busy, done, pass, table_out, mismatch_cnt,
             fail_valid, fail_idx
   );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl
//   Built-in self-test sequencer for the 3-input function unit
//   f = xy + yz + x'z. A sweep walks {x,y,z} through 000..111, holds each
//   vector for DWELL cycles so the unit can settle, samples f into a truth
//   table, and finally grades the table against the golden EXPECTED mask.
//
//   Parameters
//     DWELL     cycles each vector is held before sampling (1..255)
//     EXPECTED  golden truth table, bit i = f for {x,y,z} = i
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   tt_sweep_ctrl_if.slave (start/hold/f_in in; vector, status,
//           captured table and failure information out)
// ---------------------------------------------------------------------------
module tt_sweep_ctrl #(
   parameter int unsigned DWELL    = 4,
   parameter logic [7:0]  EXPECTED = 8'hCA
) (
   input  logic            clk,
   input  logic            rst,
   tt_sweep_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [7:0] DWELL_RELOAD = 8'(DWELL - 1);

   state_t     r_state;
   state_t     w_nextState;

   logic [2:0] r_idx;
   logic [7:0] r_cnt;
   logic [7:0] r_table;
   logic [3:0] r_mismatchCnt;
   logic       r_failValid;
   logic [2:0] r_failIdx;
   logic       r_pass;

   logic       w_accept;
   logic       w_countDown;
   logic       w_sampleFire;
   logic       w_miss;
   logic [3:0] w_mismatchNext;

   // The mismatch decision and the post-sample count are needed both for the
   // counter update and for grading pass on the last vector, where the final
   // sample must already be included in the count.
   assign w_miss         = (bus.f_in != EXPECTED[r_idx]);
   assign w_mismatchNext = r_mismatchCnt + {3'b000, w_miss};

   // State register. Reset drops straight to IDLE from anywhere, which is
   // what aborts a sweep in flight without ever pulsing done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode and the strobes that steer the datapath. Start is only
   // honoured from IDLE or DONE so a request during a sweep cannot disturb it,
   // and hold only has meaning while a sweep is running. The exit after the
   // last vector is decoded from idx==7 rather than relying on idx wrapping.
   always_comb begin
      w_nextState  = r_state;
      w_accept     = 1'b0;
      w_countDown  = 1'b0;
      w_sampleFire = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_nextState = APPLY;
            end
         end
         APPLY: begin
            if (!bus.hold) begin
               if (r_cnt == 8'd0) begin
                  w_nextState = SAMPLE;
               end else begin
                  w_countDown = 1'b1;
               end
            end
         end
         SAMPLE: begin
            if (!bus.hold) begin
               w_sampleFire = 1'b1;
               if (r_idx == 3'd7) begin
                  w_nextState = DONE;
               end else begin
                  w_nextState = APPLY;
               end
            end
         end
         DONE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_nextState = APPLY;
            end else begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Sweep datapath: vector index, dwell counter and the captured results.
   // An accepted start wipes the previous results on the same edge so the
   // table seen during a sweep only ever holds this sweep's samples. Each
   // sample records f, bumps the mismatch count, and latches the first
   // failing index only once per sweep. pass is graded on the edge that
   // enters DONE and then stays put until the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx         <= 3'd0;
         r_cnt         <= 8'd0;
         r_table       <= 8'h00;
         r_mismatchCnt <= 4'd0;
         r_failValid   <= 1'b0;
         r_failIdx     <= 3'd0;
         r_pass        <= 1'b0;
      end else if (w_accept) begin
         r_idx         <= 3'd0;
         r_cnt         <= DWELL_RELOAD;
         r_table       <= 8'h00;
         r_mismatchCnt <= 4'd0;
         r_failValid   <= 1'b0;
         r_failIdx     <= 3'd0;
         r_pass        <= 1'b0;
      end else if (w_countDown) begin
         r_cnt <= r_cnt - 8'd1;
      end else if (w_sampleFire) begin
         r_table[r_idx] <= bus.f_in;
         if (w_miss) begin
            r_mismatchCnt <= w_mismatchNext;
            if (!r_failValid) begin
               r_failValid <= 1'b1;
               r_failIdx   <= r_idx;
            end
         end
         if (r_idx == 3'd7) begin
            r_pass <= (w_mismatchNext == 4'd0);
         end else begin
            r_idx <= r_idx + 3'd1;
            r_cnt <= DWELL_RELOAD;
         end
      end
   end

   // The vector output is the index itself, so it is 000 from reset, steps
   // immediately with the index, and naturally keeps its last value in IDLE.
   assign bus.x            = r_idx[2];
   assign bus.y            = r_idx[1];
   assign bus.z            = r_idx[0];
   assign bus.busy         = (r_state == APPLY) || (r_state == SAMPLE);
   assign bus.done         = (r_state == DONE);
   assign bus.pass         = r_pass;
   assign bus.table_out    = r_table;
   assign bus.mismatch_cnt = r_mismatchCnt;
   assign bus.fail_valid   = r_failValid;
   assign bus.fail_idx     = r_failIdx;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_ctrl
//   Directed bench for tt_sweep_ctrl. Two controllers share the clock and
//   reset: one with the default DWELL of 4 and one with DWELL of 1. Each is
//   paired with a behavioural function unit that can be good, stuck at 0 or
//   inverted, and expected tables are derived from that unit's equation.
// ---------------------------------------------------------------------------
module tb_tt_sweep_ctrl;

   localparam logic [7:0] GOLDEN = 8'hCA;

   logic clk;
   logic rst;
   int   unitModeA;
   int   unitModeB;
   int   passCount;
   int   totalChecks;

   tt_sweep_ctrl_if busA ();
   tt_sweep_ctrl_if busB ();

   tt_sweep_ctrl #(.DWELL(4), .EXPECTED(GOLDEN)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (busA)
   );

   tt_sweep_ctrl #(.DWELL(1), .EXPECTED(GOLDEN)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural function unit: mode 0 good, 1 stuck at 0, 2 inverted.
   function automatic logic unitF(input int mode, input logic x, input logic y, input logic z);
      logic f;
      f = (x & y) | (y & z) | (~x & z);
      if (mode == 1) return 1'b0;
      if (mode == 2) return ~f;
      return f;
   endfunction

   assign busA.f_in = unitF(unitModeA, busA.x, busA.y, busA.z);
   assign busB.f_in = unitF(unitModeB, busB.x, busB.y, busB.z);

   // Truth table the unit in a given mode should produce.
   function automatic logic [7:0] expTable(input int mode);
      logic [7:0] t;
      logic [2:0] v;
      t = 8'h00;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         t[i] = unitF(mode, v[2], v[1], v[0]);
      end
      return t;
   endfunction

   // Vector expected on the outputs c cycles after the start edge when hold
   // stalls the sweep for holdLen edges beginning right after cycle holdAt.
   function automatic logic [2:0] expVec(input int c, input int holdAt, input int holdLen, input int dwell);
      int p;
      if (c <= holdAt)                p = c;
      else if (c <= holdAt + holdLen) p = holdAt;
      else                            p = c - holdLen;
      return 3'(p / (dwell + 1));
   endfunction

   // Single comparison point: counts it, reports it if it disagrees.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Grades the end-of-sweep results of either controller against a unit mode.
   task automatic checkResults(input string tag, input int mode, input logic [7:0] tbl,
                               input logic pass, input logic [3:0] mm,
                               input logic fv, input logic [2:0] fi);
      logic [7:0] expT;
      logic [7:0] diff;
      int         expMm;
      int         expFi;
      expT  = expTable(mode);
      diff  = expT ^ GOLDEN;
      expMm = 0;
      expFi = -1;
      for (int i = 0; i < 8; i++) begin
         if (diff[i]) begin
            expMm++;
            if (expFi < 0) expFi = i;
         end
      end
      checkOutput({tag, ".table"}, 32'(tbl), 32'(expT));
      checkOutput({tag, ".pass"}, 32'(pass), 32'(expMm == 0));
      checkOutput({tag, ".mismatch"}, 32'(mm), 32'(expMm));
      checkOutput({tag, ".failValid"}, 32'(fv), 32'(expMm != 0));
      if (expMm != 0) checkOutput({tag, ".failIdx"}, 32'(fi), 32'(expFi));
   endtask

   // Runs one sweep on controller A and returns the cycles from the start
   // edge to the first observed done. Optionally pulses start itself, pulses
   // a stray start mid-sweep, applies a hold window and checks the vector
   // and busy every cycle.
   task automatic applyStimulus(input string tag, input bit doStart, input int holdAt,
                                input int holdLen, input int strayStartAt, output int cycles);
      if (doStart) begin
         busA.start = 1'b1;
         @(negedge clk);
         busA.start = 1'b0;
      end
      cycles = 0;
      while (busA.done !== 1'b1 && cycles < 200) begin
         checkOutput({tag, ".vec"}, 32'({busA.x, busA.y, busA.z}),
                     32'(expVec(cycles, holdAt, holdLen, 4)));
         checkOutput({tag, ".busy"}, 32'(busA.busy), 32'd1);
         busA.hold  = (cycles >= holdAt) && (cycles < holdAt + holdLen);
         busA.start = (cycles == strayStartAt);
         @(negedge clk);
         cycles++;
      end
      busA.hold  = 1'b0;
      busA.start = 1'b0;
      checkOutput({tag, ".doneSeen"}, 32'(busA.done), 32'd1);
   endtask

   initial begin
      int  cycles;
      bit  doneSeen;

      passCount   = 0;
      totalChecks = 0;
      unitModeA   = 0;
      unitModeB   = 2;
      busA.start  = 1'b0;
      busA.hold   = 1'b0;
      busB.start  = 1'b0;
      busB.hold   = 1'b0;
      rst         = 1'b1;

      // Power-on reset state.
      #1;
      checkOutput("por.vec", 32'({busA.x, busA.y, busA.z}), 32'd0);
      checkOutput("por.busy", 32'(busA.busy), 32'd0);
      checkOutput("por.done", 32'(busA.done), 32'd0);
      checkOutput("por.pass", 32'(busA.pass), 32'd0);
      checkOutput("por.table", 32'(busA.table_out), 32'd0);
      checkOutput("por.mismatch", 32'(busA.mismatch_cnt), 32'd0);
      checkOutput("por.failValid", 32'(busA.fail_valid), 32'd0);
      checkOutput("por.failIdx", 32'(busA.fail_idx), 32'd0);
      #11 rst = 1'b0;
      @(negedge clk);

      // Good unit: 5 cycles per vector, done 40 cycles after start.
      applyStimulus("good", 1'b1, -1, 0, -1, cycles);
      checkOutput("good.latency", 32'(cycles), 32'd40);
      checkOutput("good.busyInDone", 32'(busA.busy), 32'd0);
      checkResults("good", 0, busA.table_out, busA.pass, busA.mismatch_cnt,
                   busA.fail_valid, busA.fail_idx);
      @(negedge clk);
      checkOutput("good.donePulse", 32'(busA.done), 32'd0);
      checkOutput("good.idleBusy", 32'(busA.busy), 32'd0);
      checkOutput("good.passHeld", 32'(busA.pass), 32'd1);
      checkOutput("good.vecHeld", 32'({busA.x, busA.y, busA.z}), 32'd7);

      // Stuck-at-0 unit.
      unitModeA = 1;
      applyStimulus("stuck0", 1'b1, -1, 0, -1, cycles);
      checkOutput("stuck0.latency", 32'(cycles), 32'd40);
      checkResults("stuck0", 1, busA.table_out, busA.pass, busA.mismatch_cnt,
                   busA.fail_valid, busA.fail_idx);
      @(negedge clk);

      // Hold for 7 cycles during vector 3 stretches it to 12 cycles.
      unitModeA = 0;
      applyStimulus("hold", 1'b1, 16, 7, -1, cycles);
      checkOutput("hold.latency", 32'(cycles), 32'd47);
      checkResults("hold", 0, busA.table_out, busA.pass, busA.mismatch_cnt,
                   busA.fail_valid, busA.fail_idx);
      @(negedge clk);

      // Stray start while busy is ignored; start in the done cycle restarts.
      unitModeA = 1;
      applyStimulus("stray", 1'b1, -1, 0, 10, cycles);
      checkOutput("stray.latency", 32'(cycles), 32'd40);
      checkResults("stray", 1, busA.table_out, busA.pass, busA.mismatch_cnt,
                   busA.fail_valid, busA.fail_idx);
      unitModeA  = 0;
      busA.start = 1'b1;
      @(negedge clk);
      busA.start = 1'b0;
      checkOutput("restart.busy", 32'(busA.busy), 32'd1);
      checkOutput("restart.done", 32'(busA.done), 32'd0);
      checkOutput("restart.table", 32'(busA.table_out), 32'd0);
      checkOutput("restart.mismatch", 32'(busA.mismatch_cnt), 32'd0);
      checkOutput("restart.failValid", 32'(busA.fail_valid), 32'd0);
      applyStimulus("restart", 1'b0, -1, 0, -1, cycles);
      checkOutput("restart.latency", 32'(cycles), 32'd40);
      checkResults("restart", 0, busA.table_out, busA.pass, busA.mismatch_cnt,
                   busA.fail_valid, busA.fail_idx);
      @(negedge clk);

      // Reset mid-sweep: outputs clear asynchronously and done never pulses.
      busA.start = 1'b1;
      @(negedge clk);
      busA.start = 1'b0;
      repeat (25) @(negedge clk);
      checkOutput("midrun.busy", 32'(busA.busy), 32'd1);
      checkOutput("midrun.table", 32'(busA.table_out), 32'h0A);
      checkOutput("midrun.vec", 32'({busA.x, busA.y, busA.z}), 32'd5);
      #2 rst = 1'b1;
      #1;
      checkOutput("asyncRst.vec", 32'({busA.x, busA.y, busA.z}), 32'd0);
      checkOutput("asyncRst.busy", 32'(busA.busy), 32'd0);
      checkOutput("asyncRst.done", 32'(busA.done), 32'd0);
      checkOutput("asyncRst.table", 32'(busA.table_out), 32'd0);
      checkOutput("asyncRst.pass", 32'(busA.pass), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      doneSeen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (busA.done === 1'b1 || busA.busy === 1'b1) doneSeen = 1'b1;
      end
      checkOutput("afterRst.quiet", 32'(doneSeen), 32'd0);

      // DWELL=1 controller with an inverted unit: 2 cycles per vector.
      busB.start = 1'b1;
      @(negedge clk);
      busB.start = 1'b0;
      cycles = 0;
      while (busB.done !== 1'b1 && cycles < 100) begin
         checkOutput("dwell1.vec", 32'({busB.x, busB.y, busB.z}),
                     32'(expVec(cycles, -1, 0, 1)));
         @(negedge clk);
         cycles++;
      end
      checkOutput("dwell1.doneSeen", 32'(busB.done), 32'd1);
      checkOutput("dwell1.latency", 32'(cycles), 32'd16);
      checkResults("dwell1", 2, busB.table_out, busB.pass, busB.mismatch_cnt,
                   busB.fail_valid, busB.fail_idx);
      checkOutput("dwell1.tableConst", 32'(busB.table_out), 32'h35);
      checkOutput("dwell1.mmConst", 32'(busB.mismatch_cnt), 32'd8);

      $display("%0d/%0d checks passed", passCount, totalChecks);
      $finish;
   end

endmodule
